// File: rtl/types_pkg.sv
// -----------------------------------------------------------------------------
// types_pkg
// Shared fetch/decode type definitions.
//   fetch_state_t      : fetch front-end state (IDLE, RUN, HALT)
//   NOPE_INSTR_DEFAULT : word shown to decode when no instruction is valid
//   sat_inc32          : saturating 32-bit increment (performance counters)
// -----------------------------------------------------------------------------
package types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } fetch_state_t;

    localparam logic [31:0] NOPE_INSTR_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the instruction-memory request/response bus and the decode-side
// handshake of the fetch unit.
//   master : fetch unit side (drives ImemReq/ImemAddr, Instr/InstrPC/InstrValid,
//            Halted; receives memory responses and decode controls)
//   slave  : environment side (memory + decoder)
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  ImemReq;
    logic [ADDR_WIDTH-1:0] ImemAddr;
    logic                  ImemReady;
    logic                  ImemRvalid;
    logic [31:0]           ImemRdata;
    logic [31:0]           Instr;
    logic [ADDR_WIDTH-1:0] InstrPC;
    logic                  InstrValid;
    logic                  InstrReady;
    logic                  Redirect;
    logic [ADDR_WIDTH-1:0] RedirectPC;
    logic                  HaltSignal;
    logic                  Halted;

    modport master (
        output ImemReq, ImemAddr, Instr, InstrPC, InstrValid, Halted,
        input  ImemReady, ImemRvalid, ImemRdata, InstrReady, Redirect,
               RedirectPC, HaltSignal
    );

    modport slave (
        input  ImemReq, ImemAddr, Instr, InstrPC, InstrValid, Halted,
        output ImemReady, ImemRvalid, ImemRdata, InstrReady, Redirect,
               RedirectPC, HaltSignal
    );
endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch FIFO. Head word/valid come straight from storage
// registers, so a push in cycle N is visible at the head in cycle N+1.
// Ports:
//   clk, rstn              : clock, async active-low reset
//   push, push_data        : write an entry (ignored when full)
//   pop                    : remove head (ignored when empty)
//   flush                  : drop all entries (wins over push/pop)
//   head_data, head_valid  : oldest entry
//   count                  : occupancy
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(32'd1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop against full/empty.
    always_comb begin
        push_ok_s = push && (count_r != DEPTH_C);
        pop_ok_s  = pop && (count_r != ZERO_C);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_C;
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_C;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head view and occupancy outputs.
    always_comb begin
        head_data  = mem_r[rd_ptr_r];
        head_valid = (count_r != ZERO_C);
        count      = count_r;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch front end: holds the PC, issues in-order instruction-memory requests,
// buffers responses in fetch_fifo and hands one instruction per handshake to
// decode. Redirects flush the FIFO and discard in-flight responses; HaltSignal
// stops further fetching.
// Ports:
//   clk, rstn  : clock, async active-low reset
//   bus        : instr_fetch_unit_if.master (memory bus + decode handshake)
//   FetchCount, BubbleCount : only when FETCH_PERF_EN is defined; saturating
//                counts of popped instructions and empty-head RUN cycles
// Configuration macro: FETCH_PERF_EN
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import types_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}},
    parameter logic [31:0]           NOPE_INSTR = NOPE_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
`endif
);
    localparam int                    CW      = $clog2(FIFO_DEPTH + 1);
    localparam int                    CW1     = CW + 1;
    localparam int                    EW      = ADDR_WIDTH + 32;
    localparam logic [CW1-1:0]        DEPTH_L = CW1'(FIFO_DEPTH);
    localparam logic [CW-1:0]         ONE_C   = CW'(32'd1);
    localparam logic [CW-1:0]         ZERO_C  = {CW{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(32'd4);

    fetch_state_t          state_r;
    fetch_state_t          state_next_s;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] resp_pc_r;
    logic [ADDR_WIDTH-1:0] redirect_pc_s;
    logic [CW-1:0]         inflight_r;
    logic [CW-1:0]         inflight_next_s;
    logic [CW-1:0]         drop_r;
    logic [CW-1:0]         drop_next_s;
    logic [CW-1:0]         count_s;
    logic                  req_s;
    logic                  accept_s;
    logic                  resp_s;
    logic                  keep_s;
    logic                  pop_s;
    logic [EW-1:0]         head_data_s;
    logic                  head_valid_s;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CW)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (keep_s),
        .push_data  ({resp_pc_r, bus.ImemRdata}),
        .pop        (pop_s),
        .flush      (bus.Redirect),
        .head_data  (head_data_s),
        .head_valid (head_valid_s),
        .count      (count_s)
    );

    // Request issue and response classification. Counting in-flight requests
    // against FIFO space means every response always finds a free slot.
    always_comb begin
        redirect_pc_s = {bus.RedirectPC[ADDR_WIDTH-1:2], 2'b00};
        req_s         = (state_r == RUN) && !bus.Redirect &&
                        (({1'b0, count_s} + {1'b0, inflight_r}) < DEPTH_L);
        accept_s      = req_s && bus.ImemReady;
        resp_s        = bus.ImemRvalid && (inflight_r != ZERO_C);
        keep_s        = resp_s && (drop_r == ZERO_C) && !bus.Redirect;
        pop_s         = head_valid_s && bus.InstrReady;
    end

    // In-flight and discard counters; a redirect marks everything still
    // outstanding after this cycle's accept/response as stale.
    always_comb begin
        inflight_next_s = inflight_r;
        drop_next_s     = drop_r;
        if (accept_s && !resp_s) begin
            inflight_next_s = inflight_r + ONE_C;
        end else if (!accept_s && resp_s) begin
            inflight_next_s = inflight_r - ONE_C;
        end else begin
            inflight_next_s = inflight_r;
        end
        if (bus.Redirect) begin
            drop_next_s = inflight_next_s;
        end else if (resp_s && (drop_r != ZERO_C)) begin
            drop_next_s = drop_r - ONE_C;
        end else begin
            drop_next_s = drop_r;
        end
    end

    // Next-state logic; HALT is only left through reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.HaltSignal) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = RUN;
                end
            end
            RUN: begin
                if (bus.HaltSignal) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = RUN;
                end
            end
            HALT:    state_next_s = HALT;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request PC and response PC tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_r      <= RESET_PC;
            resp_pc_r <= RESET_PC;
        end else if (bus.Redirect) begin
            pc_r      <= redirect_pc_s;
            resp_pc_r <= redirect_pc_s;
        end else begin
            if (accept_s) begin
                pc_r <= pc_r + PC_STEP;
            end
            if (keep_s) begin
                resp_pc_r <= resp_pc_r + PC_STEP;
            end
        end
    end

    // Outstanding-request bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_r <= ZERO_C;
            drop_r     <= ZERO_C;
        end else begin
            inflight_r <= inflight_next_s;
            drop_r     <= drop_next_s;
        end
    end

    // Output drive; Instr/InstrPC are masked when the head is empty.
    always_comb begin
        bus.ImemReq    = req_s;
        bus.ImemAddr   = pc_r;
        bus.InstrValid = head_valid_s;
        bus.Halted     = (state_r == HALT) && (inflight_r == ZERO_C);
        if (head_valid_s) begin
            bus.Instr   = head_data_s[31:0];
            bus.InstrPC = head_data_s[EW-1:32];
        end else begin
            bus.Instr   = NOPE_INSTR;
            bus.InstrPC = {ADDR_WIDTH{1'b0}};
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_r;
    logic [31:0] bubble_count_r;

    // Saturating fetch/bubble counters, active in RUN only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_count_r  <= 32'd0;
            bubble_count_r <= 32'd0;
        end else if (state_r == RUN) begin
            if (pop_s) begin
                fetch_count_r <= sat_inc32(fetch_count_r);
            end
            if (!head_valid_s) begin
                bubble_count_r <= sat_inc32(bubble_count_r);
            end
        end else begin
            fetch_count_r  <= fetch_count_r;
            bubble_count_r <= bubble_count_r;
        end
    end

    assign FetchCount  = fetch_count_r;
    assign BubbleCount = bubble_count_r;
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end fetch stage of the core, and the producer of the `Instr` word consumed by the instruction decoder. Holds the PC, issues in-order requests to instruction memory, buffers returned words in a small prefetch FIFO, and presents one instruction per handshake to decode. Handles control-flow redirects from jump/branch resolution (flush plus discard of in-flight responses) and stops fetching when the decoder raises `HaltSignal` on ebreak.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, PC / memory byte-address width
- `FIFO_DEPTH`, 4, prefetch entries; power of two, ≥2
- `RESET_PC`, 0, first fetch address; must be 4-byte aligned
- `NOPE_INSTR`, 0, word driven on `Instr` when `InstrValid`=0

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rstn`  in  1  reset, asynchronous assert, active-low
- `ImemReq`  out  1  request valid
- `ImemAddr`  out  ADDR_WIDTH  request byte address; bits [1:0] always 0
- `ImemReady`  in  1  memory accepts request this cycle
- `ImemRvalid`  in  1  response valid; responses return in request order
- `ImemRdata`  in  32  response instruction word
- `Instr`  out  32  FIFO head word, else `NOPE_INSTR`
- `InstrPC`  out  ADDR_WIDTH  address of FIFO head, 0 when invalid
- `InstrValid`  out  1  head valid
- `InstrReady`  in  1  decode consumes head
- `Redirect`  in  1  control-flow change
- `RedirectPC`  in  ADDR_WIDTH  new PC; bits [1:0] ignored (treated as 0)
- `HaltSignal`  in  1  from decoder; stop fetch
- `Halted`  out  1  fetch stopped and no requests in flight

## Operation
- State machine: `IDLE` → `RUN` → `HALT`.
  - `IDLE`: one cycle after reset release, no request; → `RUN`.
  - `RUN`: fetch.
  - `HALT` on `HaltSignal`=1; left only by reset.
- Counters: `Inflight` = accepted requests without response; `Drop` ≤ `Inflight` = in-flight responses to discard; `Count` = FIFO occupancy.
- Issue: `ImemReq` = (state==`RUN`) && !`Redirect` && (`Count` + `Inflight` < `FIFO_DEPTH`). This guarantees no response ever meets a full FIFO.
- `ImemAddr` = PC; accepted (`ImemReq`&&`ImemReady`) → PC += 4 modulo 2^ADDR_WIDTH, `Inflight`+1.
- Response: `Inflight`-1. If `Drop`>0: `Drop`-1, word discarded. Else word and its address are pushed into the FIFO. Address tracking uses a second pointer (`RespPC`) advanced by 4 per kept response.
- Pop: `InstrValid`&&`InstrReady` removes the head.
- `Redirect`:
  - FIFO cleared (same-cycle pop is irrelevant).
  - PC and `RespPC` ← {RedirectPC[ADDR_WIDTH-1:2],2'b00}.
  - `Drop` ← `Inflight` after this cycle's response/accept updates. A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
- `HaltSignal`: no further requests issued. The FIFO keeps its contents and can still be popped. `Halted`=1 once state==`HALT` && `Inflight`==0.
- Simultaneous `Redirect`+`HaltSignal`: both apply (PC updated, flush, state→`HALT`).
- Spurious `ImemRvalid` with `Inflight`==0 is ignored.

## Timing
- Reset values: `ImemReq`=0, `ImemAddr`=`RESET_PC`, `Instr`=`NOPE_INSTR`, `InstrPC`=0, `InstrValid`=0, `Halted`=0; all counters 0.
- Cycle 0 after `rstn` rises is `IDLE`. First `ImemReq` is in cycle 1 with `ImemAddr`=`RESET_PC`.
- FIFO output is registered, with no bypass: a response in cycle N is visible on `Instr` in N+1.
  - With a 1-cycle memory (always ready), request accepted at t gives `InstrValid` at t+2.
  - Steady-state throughput is 1 instruction/cycle when `FIFO_DEPTH`≥3.
- Redirect at cycle t: the first new request is in t+1, and `InstrValid`=0 at t+1.
- `rstn` low mid-operation clears everything immediately (async). Memory is reset alongside.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `FetchCount` (out, 32, instructions popped) and `BubbleCount` (out, 32, cycles in `RUN` with `InstrValid`=0).
  - Both reset to 0, saturate at 2^32-1, and do not count in `IDLE`/`HALT`.
- Undefined: these ports and the counters do not exist.

## Structure
- Shared package `types_pkg`: `fetch_state_t` enum (`IDLE`, `RUN`, `HALT`) and the `NOPE_INSTR` default constant. The package is shared with the decoder.
- One sub-module: `fetch_fifo`, a synchronous FIFO parameterised by width and depth, with push/pop/flush and a count output. Entry = {PC, word}.
- PC, counters and FSM live in the top.

## Test plan
- Reset, memory 1-cycle always-ready returning addr+0x100 as the word → `ImemAddr` 0,4,8,…; `Instr` 0x100,0x104,… with `InstrPC` 0,4,…; first `InstrValid` at cycle 3 after release.
- `InstrReady`=0 for 10 cycles → exactly `FIFO_DEPTH` (4) accepted requests, `ImemReq` low afterwards, no word lost or duplicated on resume.
- 3-cycle memory latency, `Redirect` with `RedirectPC`=0x203 while 2 requests are in flight → both stale words dropped, next head `InstrPC`=0x200, `Instr`=0x300.
- `HaltSignal` with 1 in flight → no new `ImemReq`; `Halted`=1 one cycle after the last response; remaining FIFO entries still poppable.
- PC at 2^32-4 → next `ImemAddr`=0 (wrap).
- Async `rstn` pulse mid-stream → all outputs return to reset values in the same cycle; fetch restarts at `RESET_PC`.
